// File: rtl/slot_count_gen.sv
// Count sweep for the slot-address decoder with prescaler, wrap pulse and slot seek.
// Optional pause-at-slot-start feature: SLOT_COUNT_GEN_PAUSE_EN.
module slot_count_gen #(
  parameter int DIV       = 4,
  parameter int MAX_COUNT = 174
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
`ifdef SLOT_COUNT_GEN_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       seek_valid,
  input  logic [3:0] seek_slot,
  output logic       seek_ready,
  output logic [7:0] count,
  output logic [3:0] slot,
  output logic       wrap
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [7:0] MAXC = 8'(MAX_COUNT);

  typedef enum logic {RUN, SEEK} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [7:0]    count_q;
  logic [3:0]    slot_q;
  logic          wrap_q;
  logic          ready_q;

  function automatic logic [7:0] slot_start(input logic [3:0] s);
    logic [7:0] r;
    case (s)
      4'd0:    r = 8'd0;
      4'd15:   r = 8'd164;
      default: r = {4'd0, s} * 8'd11 - 8'd1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] slot_of(input logic [7:0] c);
    logic [3:0] r;
    r = 4'd0;
    for (int s = 1; s < 16; s++) begin
      if (c >= slot_start(4'(s))) r = 4'(s);
    end
    return r;
  endfunction

  logic       accept;
  logic [7:0] tgt;
  logic       clamp;
  logic       hold;
  logic       last;
  logic       step;
  logic [7:0] count_d;
  logic [3:0] slot_d;
  logic [DW-1:0] div_d;

  assign accept = seek_valid & ready_q;
  assign tgt    = slot_start(seek_slot);
  assign clamp  = tgt > MAXC;

`ifdef SLOT_COUNT_GEN_PAUSE_EN
  // Paused only once the count sits exactly on a slot's first value.
  assign hold = pause & (count_q == slot_start(slot_q));
`else
  assign hold = 1'b0;
`endif

  assign last    = div_q == DIV_LAST;
  assign step    = en & ~hold & last & (state_q == RUN);
  assign count_d = (count_q == MAXC) ? 8'd0 : count_q + 8'd1;
  assign slot_d  = slot_of(count_d);

  always_comb begin
    div_d = div_q;
    if (hold)    div_d = '0;
    else if (en) div_d = last ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      div_q   <= '0;
      count_q <= 8'd0;
      slot_q  <= 4'd0;
      wrap_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (accept) begin
            count_q <= clamp ? 8'd0 : tgt;
            slot_q  <= clamp ? 4'd0 : seek_slot;
            div_q   <= '0;
            state_q <= SEEK;
            ready_q <= 1'b0;
          end else begin
            div_q <= div_d;
            if (step) begin
              count_q <= count_d;
              slot_q  <= slot_d;
              wrap_q  <= count_q == MAXC;
            end
          end
        end
        SEEK: begin
          state_q <= RUN;
          ready_q <= 1'b1;
          div_q   <= div_d;
        end
      endcase
    end
  end

  assign seek_ready = ready_q;
  assign count      = count_q;
  assign slot       = slot_q;
  assign wrap       = wrap_q;

endmodule
